// File: rtl/demultiplexer_4_16_if.sv
// Bundle of the demultiplexer's data-path signals: one valid/ready input port with an
// address, NUM_OUTPUTS valid/ready output channels and the misroute counter.
interface demultiplexer_4_16_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_OUTPUTS = 13,
    parameter int CNT_WIDTH   = 8
);
    logic                              demux_in_valid;
    logic                              demux_in_ready;
    logic [ADDR_WIDTH-1:0]             demux_address;
    logic [DATA_WIDTH-1:0]             demux_input;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] demux_output;
    logic [NUM_OUTPUTS-1:0]            demux_out_valid;
    logic [NUM_OUTPUTS-1:0]            demux_out_ready;
    logic [CNT_WIDTH-1:0]              demux_misroute_cnt;

    // The producer/consumer side drives the input word and the per-channel ready.
    modport master (
        output demux_in_valid,
        output demux_address,
        output demux_input,
        output demux_out_ready,
        input  demux_in_ready,
        input  demux_output,
        input  demux_out_valid,
        input  demux_misroute_cnt
    );

    modport slave (
        input  demux_in_valid,
        input  demux_address,
        input  demux_input,
        input  demux_out_ready,
        output demux_in_ready,
        output demux_output,
        output demux_out_valid,
        output demux_misroute_cnt
    );
endinterface

// File: rtl/demultiplexer_4_16.sv
// Registered 1-to-N demultiplexer: each accepted word lands in the one-entry holding
// register of its addressed channel; out-of-range addresses go to channel 0 and are counted.
module demultiplexer_4_16 #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_OUTPUTS = 13,
    parameter int CNT_WIDTH   = 8
) (
    input logic                 clk,
    input logic                 rst,
    demultiplexer_4_16_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] CHANNEL_LIMIT = NUM_OUTPUTS[ADDR_WIDTH:0];

    logic                   in_range;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   in_ready;
    logic                   accept;
    logic [NUM_OUTPUTS-1:0] write_sel;
    logic [NUM_OUTPUTS-1:0] valid_q;
    logic [DATA_WIDTH-1:0]  data_q [NUM_OUTPUTS];
    logic [CNT_WIDTH-1:0]   cnt_q;

    assign in_range = {1'b0, bus.demux_address} < CHANNEL_LIMIT;
    assign target   = in_range ? bus.demux_address : '0;

    // A full channel can still take a word in the same cycle its consumer drains it.
    assign in_ready = !rst && (!valid_q[target] || bus.demux_out_ready[target]);
    assign accept   = bus.demux_in_valid && in_ready;

    always_comb begin
        write_sel = '0;
        if (accept) begin
            write_sel[target] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // A write wins over a drain so back-to-back traffic keeps valid high.
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (write_sel[k]) begin
                    data_q[k]  <= bus.demux_input;
                    valid_q[k] <= 1'b1;
                end else if (valid_q[k] && bus.demux_out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (accept && !in_range && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
        assign bus.demux_output[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

    assign bus.demux_in_ready     = in_ready;
    assign bus.demux_out_valid    = valid_q;
    assign bus.demux_misroute_cnt = cnt_q;
endmodule
